// File: rtl/twobit_async_up_rst.sv
// Free-running up counter with a synchronous, active-high reset.
// Count is taken straight from the state register; rst is only sampled on Clk.
module twobit_async_up_rst #(
   parameter int unsigned           WIDTH   = 2,
   parameter logic [WIDTH-1:0]      RST_VAL = 2'b00
) (
   input  logic             Clk,
   input  logic             rst,
   output logic [WIDTH-1:0] Count
);

   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] count_q;

   // Toggle-counter step: bit i flips when every lower bit is 1, so bit 0
   // flips every edge and bit 1 flips only when bit 0 falls.
   function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] cur);
      logic [WIDTH-1:0] nxt;
      logic             carry;
      carry = 1'b1;
      for (int i = 0; i < int'(WIDTH); i++) begin
         nxt[i] = cur[i] ^ carry;
         carry  = carry & cur[i];
      end
      return nxt;
   endfunction

   // Next-state selection; reset has priority over counting.
   always_comb begin
      count_d = count_q;
      if (rst) begin
         count_d = RST_VAL;
      end else begin
         count_d = next_count(count_q);
      end
   end

   // State register, clocked only by Clk (no asynchronous path from rst).
   always_ff @(posedge Clk) begin
      count_q <= count_d;
   end

   assign Count = count_q;

endmodule

// File: tb/tb_twobit_async_up_rst.sv
// Scoreboard bench for twobit_async_up_rst: a reference model pushes the
// expected count at each rising edge, a checker pops and compares 1 ns later.
module tb_twobit_async_up_rst;

   logic       Clk;
   logic       rst;
   logic [1:0] Count;

   int errors;
   int checks;

   logic [1:0] exp_q[$];
   logic [1:0] model;
   logic       model_valid;

   twobit_async_up_rst #(
      .WIDTH   (2),
      .RST_VAL (2'b00)
   ) dut (
      .Clk   (Clk),
      .rst   (rst),
      .Count (Count)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, act, exp);
      end
   endtask

   task automatic wait_until(input time t);
      if (t > $time) #(t - $time);
   endtask

   // Reference model: reset loads 0, otherwise +1 mod 4; only known after the first reset edge.
   always @(posedge Clk) begin
      if (rst) begin
         model       = 2'd0;
         model_valid = 1'b1;
      end else if (model_valid) begin
         model = model + 2'd1;
      end
      if (model_valid) exp_q.push_back(model);
   end

   // Compare DUT output against the scoreboard just after each edge.
   always @(posedge Clk) begin
      #1;
      if (exp_q.size() > 0) chk("sb_count", {30'd0, Count}, {30'd0, exp_q.pop_front()});
   end

   initial begin
      errors      = 0;
      checks      = 0;
      model       = 2'd0;
      model_valid = 1'b0;

      // Power-up reset and first count cycle.
      rst = 1'b1;
      wait_until(10);  rst = 1'b0;
      wait_until(6 + 10); chk("first_inc", {30'd0, Count}, 32'd1);
      wait_until(36);  chk("reach_11", {30'd0, Count}, 32'd3);
      wait_until(46);  chk("wrap_00", {30'd0, Count}, 32'd0);
      wait_until(56);  chk("wrap_01", {30'd0, Count}, 32'd1);

      // Mid-run reset from 10.
      wait_until(110); rst = 1'b1;
      wait_until(116); chk("midrun_rst", {30'd0, Count}, 32'd0);
      wait_until(120); rst = 1'b0;
      wait_until(136); chk("midrun_10", {30'd0, Count}, 32'd2);

      // Held reset for five edges (145..185) starting from 10.
      wait_until(140); rst = 1'b1;
      wait_until(166); chk("held_rst", {30'd0, Count}, 32'd0);
      wait_until(186); chk("held_rst_last", {30'd0, Count}, 32'd0);
      wait_until(190); rst = 1'b0;
      wait_until(196); chk("held_release", {30'd0, Count}, 32'd1);

      // Reset sampled on the edge where Count is 11.
      wait_until(216); chk("term_11", {30'd0, Count}, 32'd3);
      wait_until(220); rst = 1'b1;
      wait_until(226); chk("term_rst", {30'd0, Count}, 32'd0);
      wait_until(230); rst = 1'b0;

      // Reset pulse entirely between the 235 and 245 edges.
      wait_until(237); rst = 1'b1;
      wait_until(240); chk("pulse_hold", {30'd0, Count}, 32'd1);
      wait_until(243); rst = 1'b0;
      wait_until(246); chk("pulse_ignored", {30'd0, Count}, 32'd2);

      // Random reset traffic, rst changed on falling edges only.
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         chk("stable_mid", {30'd0, Count}, {30'd0, model});
         rst = ($urandom_range(0, 3) == 0);
      end
      @(negedge Clk);
      rst = 1'b0;
      @(posedge Clk);
      #2;
      chk("sb_drain", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
